dll_loop_filter_pi: RTL

//  Parametrised PI loop filter for the code-tracking DLL. Replaces the truncating
//  P-only stage. Takes one early/late energy pair per integrate-and-dump and forms
//  a raw (E-L) or normalised (E-L)/(E+L) discriminator; normalised mode uses a

---
 rtl/dll_loop_filter_pi.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dll_loop_filter_pi.sv
// PI loop filter for the code-tracking DLL: early/late discriminator (raw or normalised by a
// restoring divider), saturated PI correction word and consecutive-sample code-lock detection.
module dll_loop_filter_pi #(
   parameter int unsigned EW       = 64,
   parameter int unsigned OW       = 32,
   parameter int unsigned FRAC     = 16,
   parameter int unsigned LOCK_CNT = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic signed [EW-1:0] pe_i,
   input  logic signed [EW-1:0] pl_i,
   input  logic                 norm_en_i,
   input  logic [4:0]           kp_shift_i,
   input  logic [4:0]           ki_shift_i,
   input  logic [OW-1:0]        lock_thresh_i,
   input  logic                 integ_clr_i,
   output logic signed [OW-1:0] correction_o,
   output logic signed [OW-1:0] err_out_o,
   output logic                 out_valid_o,
   output logic                 sat_flag_o,
   output logic                 lock_o
);

   localparam int unsigned CW  = $clog2(LOCK_CNT + 1);
   localparam int unsigned DCW = $clog2(FRAC + 1) + 1;
   localparam logic signed [EW:0] SatMax = {{(EW-OW+2){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [EW:0] SatMin = {{(EW-OW+2){1'b1}}, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StDiv, StFilt} state_e;

   function automatic logic [OW-1:0] sat_ow(input logic signed [EW:0] x);
      if (x > SatMax) return SatMax[OW-1:0];
      else if (x < SatMin) return SatMin[OW-1:0];
      else return x[OW-1:0];
   endfunction

   function automatic logic clamps(input logic signed [EW:0] x);
      return (x > SatMax) || (x < SatMin);
   endfunction

   state_e               state_q;
   logic signed [EW:0]   d_q;
   logic [EW:0]          s_q;
   logic                 norm_q;
   logic [4:0]           kp_q, ki_q;
   logic [EW+1:0]        rem_q;
   logic [FRAC:0]        quo_q;
   logic [DCW-1:0]       div_cnt_q;
   logic signed [OW-1:0] integ_q, corr_q, err_q;
   logic                 valid_q, sat_q, lock_q;
   logic [CW-1:0]        lcnt_q;

   logic signed [EW:0]   d_new;
   logic [EW:0]          d_new_abs, s_new;
   logic                 rem_ge;
   logic [EW+1:0]        rem_sub;
   logic signed [OW-1:0] q_ext, err_norm, err_d, integ_base, ki_term, p_term, i_next, c_next;
   logic signed [EW:0]   sum_i, sum_c;
   logic                 sat_d;
   logic [OW-1:0]        abs_err;
   logic [CW-1:0]        lcnt_d;

   always_comb begin
      d_new     = $signed({pe_i[EW-1], pe_i}) - $signed({pl_i[EW-1], pl_i});
      d_new_abs = d_new[EW] ? -d_new : d_new;
      s_new     = {1'b0, pe_i} + {1'b0, pl_i};

      // Fractional long division: |d| <= s, so each step yields one quotient bit.
      rem_ge  = rem_q >= {1'b0, s_q};
      rem_sub = rem_ge ? rem_q - {1'b0, s_q} : rem_q;

      q_ext    = $signed({{(OW-FRAC-1){1'b0}}, quo_q});
      err_norm = (s_q == '0) ? '0 : (d_q[EW] ? -q_ext : q_ext);
      err_d    = norm_q ? err_norm : $signed(sat_ow(d_q));

      integ_base = integ_clr_i ? '0 : integ_q;
      ki_term    = err_d >>> ki_q;
      sum_i      = $signed({{(EW+1-OW){integ_base[OW-1]}}, integ_base})
                 + $signed({{(EW+1-OW){ki_term[OW-1]}}, ki_term});
      i_next     = $signed(sat_ow(sum_i));
      p_term     = err_d >>> kp_q;
      sum_c      = $signed({{(EW+1-OW){p_term[OW-1]}}, p_term})
                 + $signed({{(EW+1-OW){i_next[OW-1]}}, i_next});
      c_next     = $signed(sat_ow(sum_c));
      sat_d      = clamps(sum_i) | clamps(sum_c);

      abs_err = err_d[OW-1] ? -err_d : err_d;
      lcnt_d  = '0;
      if (abs_err < lock_thresh_i) begin
         lcnt_d = (lcnt_q == CW'(LOCK_CNT)) ? lcnt_q : lcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         d_q       <= '0;
         s_q       <= '0;
         norm_q    <= 1'b0;
         kp_q      <= '0;
         ki_q      <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_cnt_q <= '0;
         integ_q   <= '0;
         corr_q    <= '0;
         err_q     <= '0;
         valid_q   <= 1'b0;
         sat_q     <= 1'b0;
         lock_q    <= 1'b0;
         lcnt_q    <= '0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (integ_clr_i) integ_q <= '0;
               if (in_valid_i) begin
                  d_q       <= d_new;
                  s_q       <= s_new;
                  norm_q    <= norm_en_i;
                  kp_q      <= kp_shift_i;
                  ki_q      <= ki_shift_i;
                  rem_q     <= {1'b0, d_new_abs};
                  quo_q     <= '0;
                  div_cnt_q <= '0;
                  state_q   <= norm_en_i ? StDiv : StFilt;
               end
            end
            StDiv: begin
               if (integ_clr_i) integ_q <= '0;
               rem_q     <= rem_sub << 1;
               quo_q     <= {quo_q[FRAC-1:0], rem_ge};
               div_cnt_q <= div_cnt_q + 1'b1;
               if (div_cnt_q == DCW'(FRAC)) state_q <= StFilt;
            end
            StFilt: begin
               integ_q <= i_next;
               corr_q  <= c_next;
               err_q   <= err_d;
               valid_q <= 1'b1;
               sat_q   <= sat_d;
               lcnt_q  <= lcnt_d;
               lock_q  <= (lcnt_d == CW'(LOCK_CNT));
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready_o   = (state_q == StIdle);
   assign correction_o = corr_q;
   assign err_out_o    = err_q;
   assign out_valid_o  = valid_q;
   assign sat_flag_o   = sat_q;
   assign lock_o       = lock_q;

endmodule
